// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled RAM bank: controller states and
// default geometry.
package ram_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DEPTH  = 128;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Storage array: one byte-enabled write port and one synchronous read port.
// Contents are never reset; the controller clears them by sweeping.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic                clock,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;

    // Callers guarantee addresses are below DEPTH, so the low bits suffice.
    assign widx = waddr_i[IDX_W-1:0];
    assign ridx = raddr_i[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe_i[b]) mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[ridx];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// RAM bank controller: clears the array after reset, range-checks requests
// and returns write-first read data with one cycle of latency.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                wr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                rd,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                err
);

    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [NB-1:0]     byp_be_q, byp_be_d;

    logic              in_range;
    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic [NB-1:0]     arr_wbe;

    assign in_range = ({1'b0, addr} < DEPTH_L);

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock   (clock),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .wbe_i   (arr_wbe),
        .re_i    (arr_re),
        .raddr_i (addr),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        zero_d     = zero_q;
        byp_data_d = byp_data_q;
        byp_be_d   = byp_be_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_waddr  = addr;
        arr_wdata  = wdata;
        arr_wbe    = be;
        case (state_q)
            INIT: begin
                arr_we    = 1'b1;
                arr_waddr = sweep_q;
                arr_wdata = '0;
                arr_wbe   = '1;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LAST) begin
                    state_d = READY;
                    sweep_d = '0;
                end
            end
            READY: begin
                arr_we   = wr & in_range;
                arr_re   = rd & in_range;
                err_d    = (wr | rd) & ~in_range;
                rvalid_d = rd;
                // The array reads the old word; lanes being written this
                // cycle are overlaid from the captured write data.
                if (rd) begin
                    zero_d     = ~in_range;
                    byp_data_d = wdata;
                    byp_be_d   = (wr && in_range) ? be : '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            zero_q     <= 1'b1;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            zero_q     <= zero_d;
            byp_data_q <= byp_data_d;
            byp_be_q   <= byp_be_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NB; b++) begin
            if (!zero_q)
                rdata[8*b +: 8] = byp_be_q[b] ? byp_data_q[8*b +: 8] : arr_rdata[8*b +: 8];
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = (state_q == INIT);

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 9, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 128, number of words (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port addr  input  ADDR_W  word address for read and write.
REQ-007 The block SHALL have port wr  input  1  write request, sampled on the clock edge.
REQ-008 The block SHALL have port wdata  input  DATA_W  write data.
REQ-009 The block SHALL have port be  input  DATA_W/8  byte enables; bit i qualifies wdata[8i+7:8i].
REQ-010 The block SHALL have port rd  input  1  read request, sampled on the clock edge.
REQ-011 The block SHALL have port rdata  output  DATA_W  registered read data.
REQ-012 The block SHALL have port rvalid  output  1  rdata valid, one-cycle pulse per accepted read.
REQ-013 The block SHALL have port busy  output  1  high while the clear sweep runs; requests ignored.
REQ-014 The block SHALL have port err  output  1  one-cycle pulse for an out-of-range request.

Function
REQ-015 The block SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-016 In INIT the block SHALL write zero to word 0, 1, ..., DEPTH-1, one word per cycle, then enter READY on the cycle after writing DEPTH-1 (busy high for exactly DEPTH cycles after reset release).
REQ-017 In INIT the block SHALL ignore wr and rd: no memory change, rvalid=0, err=0.
REQ-018 In READY, wr=1 with addr<DEPTH SHALL update only the bytes with be[i]=1 at the clock edge; be=0 SHALL leave the word unchanged.
REQ-019 In READY, rd=1 with addr<DEPTH SHALL drive rdata with the word contents and rvalid=1 one cycle later (latency 1).
REQ-020 wr=1 and rd=1 to the same address in one cycle SHALL be write-first: rdata returns the byte-merged new word.
REQ-021 rd=0 SHALL leave rdata holding its last value with rvalid=0.
REQ-022 A wr or rd with addr>=DEPTH SHALL not modify memory and SHALL pulse err=1 one cycle later; if rd was high, rvalid=1 and rdata=0 in that same cycle.
REQ-023 Back-to-back reads on consecutive cycles SHALL each produce one rvalid pulse, with no bubbles.

Reset
REQ-024 Asserting reset_n=0 at any time, including mid-sweep, SHALL immediately force rdata=0, rvalid=0, err=0, busy=1, sweep address=0, state=INIT.
REQ-025 Memory contents SHALL NOT be reset asynchronously; they are cleared only by the INIT sweep.

Structure
REQ-026 The state encoding (INIT, READY) and default parameter values SHALL be in shared package ram_pkg.
REQ-027 Storage SHALL be a sub-module ram_array: one write port with byte enables and one synchronous read port, with no reset.
REQ-028 The FSM, sweep counter, range check and write-first bypass SHALL be in ram_bank.

Verification
REQ-029 Bench: release reset -> busy=1 for exactly 128 cycles; after that, rd at addr 0, 64 and 127 -> rdata=0x00000000 with rvalid pulses.
REQ-030 Bench: wr addr 0 wdata 0x22450000 be=0xF, then wr addr 1 wdata 0x10F00010 be=0xF, then rd addr 0 and rd addr 1 -> 0x22450000 then 0x10F00010, each 1 cycle after its rd.
REQ-031 Bench: addr 1 holds 0x10F00010; wr addr 1 wdata 0xAABBCCDD be=0x5 -> rd addr 1 returns 0x10BB00DD.
REQ-032 Bench: wr=1 and rd=1 together at addr 5, wdata 0x12345678, be=0xF -> next cycle rdata=0x12345678, rvalid=1.
REQ-033 Bench: rd addr 200 in READY -> next cycle err=1, rvalid=1, rdata=0; wr addr 128 -> err=1 and a later full sweep of reads shows no word changed.
REQ-034 Bench: assert reset_n=0 at sweep address 50, release -> busy stays high for a full 128 cycles again, and wr/rd during busy produce no rvalid, no err and no memory change.
